fft_output_reorder: RTL and testbench
=====================================

Name: fft_output_reorder

Overview:
- Consumer-side companion to the in-place radix-2 DIF FFT core.
- Accepts the core's two-lane result stream (two complex bins per cycle, bit-reversed order) and writes it into a ping-pong frame buffer at natural-order addresses.
- Streams each completed frame out as one complex sample per cycle, in natural bin order 0..N-1, under a valid/ready handshake.
- Sits between the FFT core output registers and downstream consumers (magnitude, framing, host interface).

Parameters:
- BW, 16, bit width of each real/imaginary component.
- N, 32, FFT length in points; must be a power of two, at least 4.
- LOGN, 5, log2(N); sets the address and bin-index width.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  lane pair on inReal0..inImag1 is valid this cycle.
- inReal0  input  BW  lane-0 real part.
- inImag0  input  BW  lane-0 imaginary part.
- inReal1  input  BW  lane-1 real part.
- inImag1  input  BW  lane-1 imaginary part.
- in_ready  output  1  a free bank exists, so a pair presented now is accepted.
- overflow  output  1  sticky flag: a pair arrived while in_ready was 0.
- out_valid  output  1  outReal/outImag/out_index hold a valid sample.
- out_ready  input  1  downstream accepts the sample this cycle.
- outReal  output  BW  natural-order sample, real part.
- outImag  output  BW  natural-order sample, imaginary part.
- out_index  output  LOGN  bin number of the current output sample.
- out_last  output  1  high with out_valid when out_index = N-1.

Behaviour:
- Reset values: in_ready=1, overflow=0, out_valid=0, outReal=0, outImag=0, out_index=0, out_last=0.
- Reset empties both banks, clears the write pair counter p and the read counter, and sets the write bank to 0.
- Reset mid-frame discards all partial and complete frames; the buffer RAM contents need not be cleared.
- Input ordering, fixed: the p-th accepted pair of a frame (p = 0..N/2-1) carries bin bitrev(2p) on lane 0 and bin bitrev(2p+1) on lane 1. bitrev is over LOGN bits. Example for N=32: p=0 gives bins 0 and 16; p=1 gives bins 8 and 24.
- Accept: a pair is accepted when in_valid and in_ready are both 1. Both lanes are written into the write bank in the same cycle (two write ports, or a bank split by address LSB), and p increments.
- Frame complete: on the accept with p = N/2-1, the write bank is marked full, p wraps to 0, and the write pointer toggles to the other bank.
- in_ready = 0 while the write bank is full (both banks full).
- Drop: in_valid with in_ready=0 drops the pair and sets overflow; overflow clears only on rst.
- Bank states: each bank is EMPTY, FILLING or FULL. The read side drains the oldest FULL bank first.
- Read FSM states:
  - IDLE: no full bank; out_valid=0.
  - PRIME: one cycle for the synchronous RAM read of address 0.
  - STREAM: out_valid=1.
- Read FSM transitions:
  - IDLE -> PRIME when a bank becomes full.
  - PRIME -> STREAM.
  - STREAM advances k on each cycle with out_valid and out_ready both 1.
  - On the handshake at k = N-1: the bank becomes EMPTY. The FSM stays in STREAM with k=0 of the other bank if that bank is already full, with no bubble; otherwise it goes to IDLE.
- Latency: the last pair is accepted at edge E. With the read side idle, out_valid rises after edge E+2 with out_index=0.
- Hold: while out_valid=1 and out_ready=0, outReal, outImag, out_index and out_last hold stable. No sample is skipped or duplicated; use a prefetch/skid register so full throughput is one sample per cycle.
- Simultaneous events:
  - Drain completing on the same edge a new frame completes: the freed bank is writable next cycle and in_ready rises next cycle. The newly full bank streams immediately afterwards.
  - Write into bank A while bank B drains is normal operation.
- Data is passed without any arithmetic change; width stays BW per component.

Test Plan:
- Single frame, N=32: lane0 = {bin, 0} and lane1 likewise, with bin = bitrev(2p) and bitrev(2p+1), 16 consecutive pairs, out_ready=1 -> out_valid 2 cycles after the last pair; outReal = 0,1,...,31 on consecutive cycles; out_last only at index 31.
- Back-to-back frames: frame A (values 0..31) then frame B (values 100..131) with no gap, out_ready=1 -> 64 contiguous out_valid cycles with no bubble between index 31 and the next index 0; B follows A.
- Backpressure: out_ready toggled 1,0,0,1 repeating during streaming -> every index 0..31 seen exactly once, in order; outputs stable while stalled.
- Overflow: three full frames sent with out_ready=0 -> in_ready falls after frame 2; the first pair of frame 3 sets overflow=1. Releasing out_ready yields frames 1 and 2 intact.
- Reset mid-stream: rst asserted at out_index=10 -> next cycle all outputs are 0 and in_ready=1; a following frame streams correctly from index 0.
- Partial frame then reset: 7 pairs, then rst, then a full frame -> only the full frame is output, with correct values.

Source files
------------

// File: rtl/fft_output_reorder_if.sv
// Stream bundle for fft_output_reorder: bit-reversed lane-pair input side and
// natural-order valid/ready output side.
interface fft_output_reorder_if #(
    parameter int BW   = 16,
    parameter int LOGN = 5
);
    logic            in_valid;
    logic [BW-1:0]   inReal0;
    logic [BW-1:0]   inImag0;
    logic [BW-1:0]   inReal1;
    logic [BW-1:0]   inImag1;
    logic            in_ready;
    logic            overflow;
    logic            out_valid;
    logic            out_ready;
    logic [BW-1:0]   outReal;
    logic [BW-1:0]   outImag;
    logic [LOGN-1:0] out_index;
    logic            out_last;

    modport master (
        output in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
        input  in_ready, overflow, out_valid, outReal, outImag, out_index, out_last
    );

    modport slave (
        input  in_valid, inReal0, inImag0, inReal1, inImag1, out_ready,
        output in_ready, overflow, out_valid, outReal, outImag, out_index, out_last
    );
endinterface

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed FFT lane pairs at natural
// addresses and streams completed frames out in bin order 0..N-1.
module fft_output_reorder #(
    parameter int BW   = 16,
    parameter int N    = 32,
    parameter int LOGN = 5
) (
    input logic                clk,
    input logic                rst,
    fft_output_reorder_if.slave bus
);
    localparam int HALF = N / 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRIME  = 2'd1,
        S_STREAM = 2'd2
    } rd_state_t;

    // Lane 0 always carries bins with MSB 0 and lane 1 bins with MSB 1, so the
    // buffer splits by bin MSB and each half needs only one write port.
    logic [2*BW-1:0] r_mem_lo [N];
    logic [2*BW-1:0] r_mem_hi [N];

    logic [1:0]      r_bank_full;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [LOGN-2:0] r_p;
    logic            r_overflow;
    rd_state_t       r_state;
    rd_state_t       w_next;
    logic [BW-1:0]   r_out_real;
    logic [BW-1:0]   r_out_imag;
    logic [LOGN-1:0] r_out_index;
    logic            r_out_last;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_frame_done;
    logic [LOGN-1:0] w_wr_addr;
    logic            w_load;
    logic            w_drain;
    logic            w_rd_bank;
    logic [LOGN-1:0] w_rd_addr;
    logic [LOGN-1:0] w_rd_word_addr;
    logic [2*BW-1:0] w_rd_word;

    function automatic logic [LOGN-2:0] bitrev_p(input logic [LOGN-2:0] v);
        logic [LOGN-2:0] res;
        res = '0;
        for (int i = 0; i < LOGN - 1; i++) begin
            res[i] = v[LOGN-2-i];
        end
        return res;
    endfunction

    assign w_in_ready     = ~r_bank_full[r_wr_bank];
    assign w_accept       = bus.in_valid & w_in_ready;
    assign w_frame_done   = w_accept & (r_p == (LOGN-1)'(HALF - 1));
    assign w_wr_addr      = {r_wr_bank, bitrev_p(r_p)};
    assign w_rd_word_addr = {w_rd_bank, w_rd_addr[LOGN-2:0]};
    assign w_rd_word      = w_rd_addr[LOGN-1] ? r_mem_hi[w_rd_word_addr]
                                              : r_mem_lo[w_rd_word_addr];

    // Buffer write port: both lanes land in the current write bank together.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_lo[w_wr_addr] <= {bus.inReal0, bus.inImag0};
            r_mem_hi[w_wr_addr] <= {bus.inReal1, bus.inImag1};
        end
    end

    // Read FSM next-state and read-port control.
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_drain   = 1'b0;
        w_rd_bank = r_rd_bank;
        w_rd_addr = r_out_index;
        case (r_state)
            S_IDLE: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_next = S_PRIME;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PRIME: begin
                w_load    = 1'b1;
                w_rd_addr = LOGN'(0);
                w_next    = S_STREAM;
            end
            S_STREAM: begin
                if (bus.out_ready) begin
                    if (r_out_index == LOGN'(N - 1)) begin
                        w_drain = 1'b1;
                        // Chain straight into the other bank when it is ready.
                        if (r_bank_full[~r_rd_bank]) begin
                            w_load    = 1'b1;
                            w_rd_bank = ~r_rd_bank;
                            w_rd_addr = LOGN'(0);
                            w_next    = S_STREAM;
                        end else if (w_frame_done && (r_wr_bank != r_rd_bank)) begin
                            w_next = S_PRIME;
                        end else begin
                            w_next = S_IDLE;
                        end
                    end else begin
                        w_load    = 1'b1;
                        w_rd_addr = r_out_index + LOGN'(1);
                        w_next    = S_STREAM;
                    end
                end else begin
                    w_next = S_STREAM;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bank bookkeeping, overflow flag, FSM state and output sample registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_full <= 2'b00;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_p         <= '0;
            r_overflow  <= 1'b0;
            r_state     <= S_IDLE;
            r_out_real  <= '0;
            r_out_imag  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_bank_full[r_wr_bank] <= 1'b1;
                r_wr_bank              <= ~r_wr_bank;
                r_p                    <= '0;
            end else if (w_accept) begin
                r_p <= r_p + (LOGN-1)'(1);
            end else begin
                r_p <= r_p;
            end
            if (w_drain) begin
                r_bank_full[r_rd_bank] <= 1'b0;
                r_rd_bank              <= ~r_rd_bank;
            end
            if (bus.in_valid && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
            r_state <= w_next;
            if (w_load) begin
                r_out_real  <= w_rd_word[2*BW-1:BW];
                r_out_imag  <= w_rd_word[BW-1:0];
                r_out_index <= w_rd_addr;
                r_out_last  <= (w_rd_addr == LOGN'(N - 1));
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.overflow  = r_overflow;
    assign bus.out_valid = (r_state == S_STREAM);
    assign bus.outReal   = r_out_real;
    assign bus.outImag   = r_out_imag;
    assign bus.out_index = r_out_index;
    assign bus.out_last  = r_out_last & (r_state == S_STREAM);
endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder: stimulus pushes expected natural-order
// samples, a negedge monitor pops and compares on every output handshake.
module tb_fft_output_reorder;
    localparam int BW   = 16;
    localparam int N    = 32;
    localparam int LOGN = 5;

    typedef struct packed {
        logic [BW-1:0]   re;
        logic [BW-1:0]   im;
        logic [LOGN-1:0] idx;
        logic            last;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   run_len;
    int   max_run;
    exp_t exp_q[$];
    logic have_hold;
    exp_t held;
    logic [3:0] bp_pat;

    fft_output_reorder_if #(.BW(BW), .LOGN(LOGN)) bus ();

    fft_output_reorder #(.BW(BW), .N(N), .LOGN(LOGN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOGN; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (LOGN - 1 - i));
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] im_of(input int v);
        return BW'(v) ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Drive npairs lane pairs of a frame whose bin k carries value base+k.
    task automatic send_frame(input int base, input int npairs, input bit exp_acc);
        exp_t e;
        for (int p = 0; p < npairs; p++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.inReal0  = BW'(base + brev(2 * p));
            bus.inImag0  = im_of(base + brev(2 * p));
            bus.inReal1  = BW'(base + brev(2 * p + 1));
            bus.inImag1  = im_of(base + brev(2 * p + 1));
            chk("in_ready_during_frame", {31'd0, bus.in_ready}, {31'd0, exp_acc});
        end
        if (exp_acc && npairs == N / 2) begin
            for (int k = 0; k < N; k++) begin
                e.re   = BW'(base + k);
                e.im   = im_of(base + k);
                e.idx  = LOGN'(k);
                e.last = (k == N - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit bp);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            #1;
            if (bp) bus.out_ready = bp_pat[c % 4];
            if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
        end
        bus.out_ready = 1'b1;
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: scoreboard pop on handshake, stability check while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid) begin
            run_len = run_len + 1;
            if (run_len > max_run) max_run = run_len;
            if (have_hold) begin
                chk("hold_stable", {bus.outReal, bus.outImag},
                    {held.re, held.im});
                chk("hold_index", {26'd0, bus.out_index, bus.out_last},
                    {26'd0, held.idx, held.last});
            end
            if (bus.out_ready) begin
                have_hold = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got index %0d with empty queue",
                             bus.out_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_real", {16'd0, bus.outReal}, {16'd0, e.re});
                    chk("out_imag", {16'd0, bus.outImag}, {16'd0, e.im});
                    chk("out_index", {27'd0, bus.out_index}, {27'd0, e.idx});
                    chk("out_last", {31'd0, bus.out_last}, {31'd0, e.last});
                end
            end else begin
                have_hold = 1'b1;
                held.re   = bus.outReal;
                held.im   = bus.outImag;
                held.idx  = bus.out_index;
                held.last = bus.out_last;
            end
        end else begin
            have_hold = 1'b0;
            run_len   = 0;
        end
    end

    initial begin
        bit seen;
        total = 0;
        bad = 0;
        run_len = 0;
        max_run = 0;
        have_hold = 1'b0;
        bp_pat = 4'b1001;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.inReal0 = '0;
        bus.inImag0 = '0;
        bus.inReal1 = '0;
        bus.inImag1 = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", {bus.outReal, bus.outImag}, 32'd0);
        chk("rst_out_index", {26'd0, bus.out_index, bus.out_last}, 32'd0);
        rst = 1'b0;

        // Single frame and two-cycle latency.
        send_frame(0, N / 2, 1'b1);
        idle_in();
        chk("lat_e0_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_e2_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_e2_index", {27'd0, bus.out_index}, 32'd0);
        wait_drain(1'b0);

        // Back-to-back frames stream without a bubble.
        max_run = 0;
        send_frame(0, N / 2, 1'b1);
        send_frame(100, N / 2, 1'b1);
        idle_in();
        wait_drain(1'b0);
        chk("b2b_contiguous", max_run, 32'd64);

        // Downstream backpressure 1,0,0,1.
        send_frame(500, N / 2, 1'b1);
        idle_in();
        wait_drain(1'b1);

        // Overflow with both banks full.
        bus.out_ready = 1'b0;
        send_frame(1000, N / 2, 1'b1);
        send_frame(2000, N / 2, 1'b1);
        idle_in();
        chk("ovf_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("ovf_before", {31'd0, bus.overflow}, 32'd0);
        send_frame(3000, N / 2, 1'b0);
        idle_in();
        chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
        bus.out_ready = 1'b1;
        wait_drain(1'b0);
        chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);

        // Reset in the middle of streaming.
        send_frame(4000, N / 2, 1'b1);
        idle_in();
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid && bus.out_index == LOGN'(10)) seen = 1'b1;
        end
        chk("midrst_reach_10", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_out_data", {bus.outReal, bus.outImag}, 32'd0);
        chk("midrst_out_index", {26'd0, bus.out_index, bus.out_last}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_overflow", {31'd0, bus.overflow}, 32'd0);
        rst = 1'b0;
        send_frame(5000, N / 2, 1'b1);
        idle_in();
        wait_drain(1'b0);

        // Partial frame discarded by reset.
        send_frame(6000, 7, 1'b1);
        idle_in();
        do_reset();
        send_frame(7000, N / 2, 1'b1);
        idle_in();
        wait_drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
